// File: rtl/nav_msg_gen.sv
// GPS legacy navigation-message bit source: 300-bit subframes clocked out at one bit per
// EPOCHS_PER_BIT C/A epochs. Define NAV_PARITY_EN to enable IS-GPS-200 word parity.
module nav_msg_gen #(
    parameter int unsigned EPOCHS_PER_BIT = 20,
    parameter int unsigned TOW_MAX        = 100799
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ena_in,
    input  logic        epoch_in,
    input  logic        tow_load_in,
    input  logic [16:0] tow_in,
    input  logic [23:0] data_word_in,
    output logic        msg_out,
    output logic        bit_strobe_out,
    output logic        subframe_start_out,
    output logic [3:0]  word_idx_out,
    output logic [16:0] tow_out
);

    localparam int unsigned       EpochW    = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
    localparam logic [EpochW-1:0] EpochLast = EpochW'(EPOCHS_PER_BIT - 1);
    localparam logic [16:0]       TowMax    = 17'(TOW_MAX);
    localparam logic [4:0]        LastBit   = 5'd29;
    localparam logic [3:0]        LastWord  = 4'd9;
    localparam logic [2:0]        LastSf    = 3'd5;
    localparam logic [7:0]        Preamble  = 8'b1000_1011;

    logic [EpochW-1:0] epoch_cnt_q, epoch_cnt_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        word_cnt_q, word_cnt_d;
    logic [2:0]        sf_id_q, sf_id_d;
    logic [16:0]       tow_q, tow_d;
    logic [28:0]       shift_q, shift_d;
    logic              sent_q, sent_d;
    logic              msg_q, msg_d;
    logic              bit_stb_q, bit_stb_d;
    logic              sf_stb_q, sf_stb_d;

    logic              qual_epoch;
    logic              boundary;
    logic              word_load;
    logic              advance;
    logic              sf_wrap;
    logic [3:0]        word_next;
    logic [16:0]       tow_inc;
    logic [23:0]       payload;
    logic [29:0]       image;

    assign qual_epoch = ena_in && epoch_in && !tow_load_in;
    assign boundary   = qual_epoch && (epoch_cnt_q == '0);
    assign word_load  = (bit_cnt_q == '0);
    // The first word after reset or a load is sent without advancing the word counter.
    assign advance    = word_load && sent_q;
    assign sf_wrap    = advance && (word_cnt_q == LastWord);
    assign word_next  = !advance ? word_cnt_q : (sf_wrap ? 4'd0 : word_cnt_q + 4'd1);
    assign tow_inc    = (tow_q >= TowMax) ? '0 : tow_q + 17'd1;

    // HOW is only built mid-subframe, so tow_q/sf_id_q already belong to the current subframe.
    always_comb begin
        case (word_next)
            4'd0:    payload = {Preamble, 14'd0, 2'b00};
            4'd1:    payload = {tow_inc, 1'b0, 1'b0, sf_id_q, 2'b00};
            default: payload = data_word_in;
        endcase
    end

`ifdef NAV_PARITY_EN
    localparam logic [23:0] Mask25 = 24'hEC7CD2;
    localparam logic [23:0] Mask26 = 24'h763E69;
    localparam logic [23:0] Mask27 = 24'hBB1F34;
    localparam logic [23:0] Mask28 = 24'h5D8F9A;
    localparam logic [23:0] Mask29 = 24'hAEC7CD;
    localparam logic [23:0] Mask30 = 24'h2DEA27;

    logic d29_q, d29_d;
    logic d30_q, d30_d;

    // Masks select d1..d24 with d1 at bit 23; parity uses the uninverted source bits.
    function automatic logic [29:0] encode_word(input logic [23:0] d, input logic p29,
                                                input logic p30);
        logic [5:0] par;
        par[5] = p29 ^ (^(d & Mask25));
        par[4] = p30 ^ (^(d & Mask26));
        par[3] = p29 ^ (^(d & Mask27));
        par[2] = p30 ^ (^(d & Mask28));
        par[1] = p30 ^ (^(d & Mask29));
        par[0] = p29 ^ (^(d & Mask30));
        return {d ^ {24{p30}}, par};
    endfunction

    assign image = encode_word(payload, d29_q, d30_q);

    always_comb begin
        d29_d = d29_q;
        d30_d = d30_q;
        if (tow_load_in) begin
            d29_d = 1'b0;
            d30_d = 1'b0;
        end else if (boundary && word_load) begin
            d29_d = image[1];
            d30_d = image[0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            d29_q <= 1'b0;
            d30_q <= 1'b0;
        end else begin
            d29_q <= d29_d;
            d30_q <= d30_d;
        end
    end
`else
    assign image = {payload, 6'b000000};
`endif

    always_comb begin
        epoch_cnt_d = epoch_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        sf_id_d     = sf_id_q;
        tow_d       = tow_q;
        shift_d     = shift_q;
        sent_d      = sent_q;
        msg_d       = msg_q;
        bit_stb_d   = 1'b0;
        sf_stb_d    = 1'b0;
        if (tow_load_in) begin
            epoch_cnt_d = '0;
            bit_cnt_d   = '0;
            word_cnt_d  = '0;
            sf_id_d     = 3'd1;
            tow_d       = (tow_in > TowMax) ? '0 : tow_in;
            shift_d     = '0;
            sent_d      = 1'b0;
            msg_d       = 1'b0;
        end else if (qual_epoch) begin
            epoch_cnt_d = (epoch_cnt_q == EpochLast) ? '0 : epoch_cnt_q + EpochW'(1);
            if (boundary) begin
                sent_d    = 1'b1;
                bit_stb_d = 1'b1;
                bit_cnt_d = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + 5'd1;
                if (word_load) begin
                    msg_d      = image[29];
                    shift_d    = image[28:0];
                    word_cnt_d = word_next;
                    sf_stb_d   = (word_next == '0);
                    if (sf_wrap) begin
                        tow_d   = tow_inc;
                        sf_id_d = (sf_id_q == LastSf) ? 3'd1 : sf_id_q + 3'd1;
                    end
                end else begin
                    msg_d   = shift_q[28];
                    shift_d = {shift_q[27:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            epoch_cnt_q <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            sf_id_q     <= 3'd1;
            tow_q       <= '0;
            shift_q     <= '0;
            sent_q      <= 1'b0;
            msg_q       <= 1'b0;
            bit_stb_q   <= 1'b0;
            sf_stb_q    <= 1'b0;
        end else begin
            epoch_cnt_q <= epoch_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            sf_id_q     <= sf_id_d;
            tow_q       <= tow_d;
            shift_q     <= shift_d;
            sent_q      <= sent_d;
            msg_q       <= msg_d;
            bit_stb_q   <= bit_stb_d;
            sf_stb_q    <= sf_stb_d;
        end
    end

    assign msg_out            = msg_q;
    assign bit_strobe_out     = bit_stb_q;
    assign subframe_start_out = sf_stb_q;
    assign word_idx_out       = word_cnt_q;
    assign tow_out            = tow_q;

endmodule

// File: tb/tb_nav_msg_gen.sv
// Scoreboard bench for nav_msg_gen: a bit-stream model pushes expected bits with their epoch
// index; every bit strobe pops and compares. Honours NAV_PARITY_EN like the design.
module tb_nav_msg_gen;

    localparam int EPB  = 20;
    localparam int TOWM = 100799;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        epoch = 1'b0;
    logic        load = 1'b0;
    logic [16:0] tow_in_s = '0;
    logic [23:0] data = '0;
    logic        msg_out, bit_strobe_out, subframe_start_out;
    logic [3:0]  word_idx_out;
    logic [16:0] tow_out;

    always #5 clk = ~clk;

    nav_msg_gen dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .ena_in             (ena),
        .epoch_in           (epoch),
        .tow_load_in        (load),
        .tow_in             (tow_in_s),
        .data_word_in       (data),
        .msg_out            (msg_out),
        .bit_strobe_out     (bit_strobe_out),
        .subframe_start_out (subframe_start_out),
        .word_idx_out       (word_idx_out),
        .tow_out            (tow_out)
    );

    typedef struct {
        logic b;
        logic sf;
        int   ep;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          ep_cnt = 0;
    int          strobe_cnt = 0;
    int          sf_cnt = 0;
    int          rx_bit = 0;
    int          rx_widx = 0;
    logic [29:0] rx_sh = '0;
    logic [29:0] rx_words[10];
    logic [29:0] m_img[10];
    int          m_tow, m_sf, m_word, m_bitno;
    logic        m_d29, m_d30;

    function automatic logic db(input logic [23:0] p, input int i);
        return p[24-i];
    endfunction

    function automatic logic [29:0] enc(input logic [23:0] p, input logic s29, input logic s30);
`ifdef NAV_PARITY_EN
        logic [5:0] q;
        q[5] = s29 ^ db(p,1) ^ db(p,2) ^ db(p,3) ^ db(p,5) ^ db(p,6) ^ db(p,10) ^ db(p,11)
             ^ db(p,12) ^ db(p,13) ^ db(p,14) ^ db(p,17) ^ db(p,18) ^ db(p,20) ^ db(p,23);
        q[4] = s30 ^ db(p,2) ^ db(p,3) ^ db(p,4) ^ db(p,6) ^ db(p,7) ^ db(p,11) ^ db(p,12)
             ^ db(p,13) ^ db(p,14) ^ db(p,15) ^ db(p,18) ^ db(p,19) ^ db(p,21) ^ db(p,24);
        q[3] = s29 ^ db(p,1) ^ db(p,3) ^ db(p,4) ^ db(p,5) ^ db(p,7) ^ db(p,8) ^ db(p,12)
             ^ db(p,13) ^ db(p,14) ^ db(p,15) ^ db(p,16) ^ db(p,19) ^ db(p,20) ^ db(p,22);
        q[2] = s30 ^ db(p,2) ^ db(p,4) ^ db(p,5) ^ db(p,6) ^ db(p,8) ^ db(p,9) ^ db(p,13)
             ^ db(p,14) ^ db(p,15) ^ db(p,16) ^ db(p,17) ^ db(p,20) ^ db(p,21) ^ db(p,23);
        q[1] = s30 ^ db(p,1) ^ db(p,3) ^ db(p,5) ^ db(p,6) ^ db(p,7) ^ db(p,9) ^ db(p,10)
             ^ db(p,14) ^ db(p,15) ^ db(p,16) ^ db(p,17) ^ db(p,18) ^ db(p,21) ^ db(p,22)
             ^ db(p,24);
        q[0] = s29 ^ db(p,3) ^ db(p,5) ^ db(p,6) ^ db(p,8) ^ db(p,9) ^ db(p,10) ^ db(p,11)
             ^ db(p,13) ^ db(p,15) ^ db(p,19) ^ db(p,22) ^ db(p,23) ^ db(p,24);
        return {p ^ {24{s30}}, q};
`else
        return {p, 6'b000000} | {29'd0, s29 & s30 & 1'b0};
`endif
    endfunction

    task automatic push_word(input logic [23:0] dw);
        logic [23:0] p;
        logic [16:0] how_tow;
        logic [29:0] img;
        exp_t        e;
        how_tow = (m_tow == TOWM) ? 17'd0 : 17'(m_tow + 1);
        case (m_word)
            0:       p = {8'h8B, 16'h0000};
            1:       p = {how_tow, 2'b00, 3'(m_sf), 2'b00};
            default: p = dw;
        endcase
        img = enc(p, m_d29, m_d30);
        m_img[m_word] = img;
        for (int i = 0; i < 30; i++) begin
            e.b  = img[29-i];
            e.sf = (m_word == 0) && (i == 0);
            e.ep = 1 + m_bitno * EPB;
            exp_q.push_back(e);
            m_bitno++;
        end
        m_d29 = img[1];
        m_d30 = img[0];
        if (m_word == 9) begin
            m_word = 0;
            m_tow  = (m_tow == TOWM) ? 0 : m_tow + 1;
            m_sf   = (m_sf == 5) ? 1 : m_sf + 1;
        end else begin
            m_word++;
        end
    endtask

    task automatic push_subframe(input logic [23:0] dw);
        for (int w = 0; w < 10; w++) push_word(dw);
    endtask

    // One clock; outputs sampled 1 time unit after the edge, strobes checked against the queue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (subframe_start_out && !bit_strobe_out) begin
            n_tests++;
            n_fail++;
            $display("FAIL sf_without_bit: subframe_start=1 bit_strobe=0, required bit_strobe=1");
        end
        if (bit_strobe_out) begin
            strobe_cnt++;
            if (subframe_start_out) begin
                sf_cnt++;
                rx_bit  = 0;
                rx_widx = 0;
            end
            rx_sh = {rx_sh[28:0], msg_out};
            rx_bit++;
            if (rx_bit == 30) begin
                if (rx_widx < 10) rx_words[rx_widx] = rx_sh;
                rx_widx++;
                rx_bit = 0;
            end
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: strobe at epoch %0d, required none", ep_cnt);
            end else begin
                e = exp_q.pop_front();
                if (msg_out !== e.b || subframe_start_out !== e.sf || ep_cnt != e.ep) begin
                    n_fail++;
                    $display("FAIL bit_stream: got msg=%b sf=%b epoch=%0d, required msg=%b sf=%b epoch=%0d",
                             msg_out, subframe_start_out, ep_cnt, e.b, e.sf, e.ep);
                end
            end
        end
    endtask

    task automatic run_epochs(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            epoch = 1'b1;
            if (ena && !load) ep_cnt++;
            tick();
            epoch = 1'b0;
            for (int j = 0; j < gap; j++) tick();
        end
    endtask

    task automatic do_load(input logic [16:0] t, input logic with_epoch);
        exp_q.delete();
        load     = 1'b1;
        tow_in_s = t;
        epoch    = with_epoch;
        tick();
        load       = 1'b0;
        epoch      = 1'b0;
        ep_cnt     = 0;
        strobe_cnt = 0;
        sf_cnt     = 0;
        rx_bit     = 0;
        rx_widx    = 0;
        m_tow      = (int'(t) > TOWM) ? 0 : int'(t);
        m_sf       = 1;
        m_word     = 0;
        m_bitno    = 0;
        m_d29      = 1'b0;
        m_d30      = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_msg", 32'(msg_out), 32'd0);
        chk("reset_bit_strobe", 32'(bit_strobe_out), 32'd0);
        chk("reset_sf_strobe", 32'(subframe_start_out), 32'd0);
        chk("reset_word_idx", 32'(word_idx_out), 32'd0);
        chk("reset_tow", 32'(tow_out), 32'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_tlm();
        logic [29:0] req;
        data = 24'h3C5A96;
        ena  = 1'b1;
        do_load(17'd0, 1'b0);
        push_word(data);
        run_epochs(600, 2);
`ifdef NAV_PARITY_EN
        req = m_img[0];
`else
        req = 30'h22C00000;
`endif
        chk("tlm_word", 32'(rx_words[0]), 32'(req));
        chk("tlm_strobe_count", 32'(strobe_cnt), 32'd30);
        chk("tlm_sf_count", 32'(sf_cnt), 32'd1);
        chk("tlm_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("tlm_word_idx", 32'(word_idx_out), 32'd0);
    endtask

    task automatic test_how_sf_sequence();
        logic [23:0] how;
        data = 24'h5A5A5A;
        do_load(17'd100, 1'b0);
        for (int k = 0; k < 6; k++) begin
            push_subframe(data);
            run_epochs(6000, 0);
            how = rx_words[1][29:6] ^ {24{rx_words[0][0]}};
            chk("how_tow_field", 32'(how[23:7]), 32'(101 + k));
            chk("how_sf_id", 32'(how[4:2]), 32'((k % 5) + 1));
            chk("sf_tow_out", 32'(tow_out), 32'(100 + k));
            chk("sf_word_idx_end", 32'(word_idx_out), 32'd9);
            chk("sf_queue_drained", 32'(exp_q.size()), 32'd0);
        end
        chk("sf_count", 32'(sf_cnt), 32'd6);
    endtask

    task automatic test_tow_wrap();
        logic [23:0] how;
        data = 24'h0F0F0F;
        do_load(17'd100799, 1'b0);
        push_subframe(data);
        run_epochs(6000, 0);
        how = rx_words[1][29:6] ^ {24{rx_words[0][0]}};
        chk("wrap_how_field", 32'(how[23:7]), 32'd0);
        chk("wrap_tow_before", 32'(tow_out), 32'd100799);
        push_word(data);
        run_epochs(1, 0);
        chk("wrap_tow_after", 32'(tow_out), 32'd0);
        chk("wrap_word_idx", 32'(word_idx_out), 32'd0);
        chk("wrap_sf_count", 32'(sf_cnt), 32'd2);
        // Out-of-range TOW with a coincident epoch that must be dropped.
        do_load(17'h1FFFF, 1'b1);
        chk("oor_tow_loads_zero", 32'(tow_out), 32'd0);
        chk("load_clears_msg", 32'(msg_out), 32'd0);
        push_word(data);
        run_epochs(1, 0);
        chk("load_first_bit", 32'(msg_out), 32'd1);
        chk("load_first_strobes", 32'(strobe_cnt), 32'd1);
    endtask

    task automatic test_freeze();
        logic       saved_msg;
        logic [3:0] saved_idx;
        int         saved_cnt;
        data = 24'hC3C3C3;
        do_load(17'd5, 1'b0);
        push_word(data);
        run_epochs(90, 0);
        saved_msg = msg_out;
        saved_idx = word_idx_out;
        saved_cnt = strobe_cnt;
        chk("freeze_pre_msg", 32'(saved_msg), 32'd1);
        ena = 1'b0;
        run_epochs(50, 1);
        chk("freeze_msg_held", 32'(msg_out), 32'(saved_msg));
        chk("freeze_no_strobes", 32'(strobe_cnt), 32'(saved_cnt));
        chk("freeze_word_idx", 32'(word_idx_out), 32'(saved_idx));
        ena = 1'b1;
        run_epochs(510, 0);
        chk("freeze_resume_strobes", 32'(strobe_cnt), 32'd30);
        chk("freeze_queue_drained", 32'(exp_q.size()), 32'd0);
        ena = 1'b0;
        do_load(17'd77, 1'b0);
        chk("disabled_load_tow", 32'(tow_out), 32'd77);
        chk("disabled_load_word_idx", 32'(word_idx_out), 32'd0);
        ena = 1'b1;
    endtask

    task automatic test_parity();
        data = 24'hFFFFFF;
        do_load(17'd0, 1'b0);
        push_subframe(data);
        run_epochs(6000, 0);
        chk("parity_queue_drained", 32'(exp_q.size()), 32'd0);
        for (int w = 0; w < 10; w++) chk("parity_word", 32'(rx_words[w]), 32'(m_img[w]));
        for (int w = 2; w < 10; w++) begin
            chk("parity_inversion", 32'(rx_words[w][29:6]),
                rx_words[w-1][0] ? 32'h000000 : 32'hFFFFFF);
        end
    endtask

    initial begin
        test_reset();
        test_tlm();
        test_how_sf_sequence();
        test_tow_wrap();
        test_freeze();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
